// File: rtl/lookahead_port_buffer_array.sv
// lookahead_port_buffer_array: per-port elastic FIFOs between a lookahead router and its neighbours.
// Each enabled port keeps StopLatency entries of headroom so in-flight flits after stop_out are absorbed.
module lookahead_port_buffer_array #(
    parameter int         Width       = 66,
    parameter logic [4:0] Ports       = 5'b11111,
    parameter int         Depth       = 4,
    parameter int         StopLatency = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [5*Width-1:0]              data_in,
    input  logic [4:0]                      data_void_in,
    output logic [4:0]                      stop_out,
    output logic [5*Width-1:0]              data_out,
    output logic [4:0]                      data_void_out,
    input  logic [4:0]                      stop_in,
    output logic [5*$clog2(Depth+1)-1:0]    occupancy,
    output logic [4:0]                      overflow_err
);
    localparam int CW = $clog2(Depth + 1);
    localparam int PW = $clog2(Depth);

    if (Depth < 2 || Depth <= StopLatency) begin : g_bad_depth
        $error("Depth must be >= 2 and greater than StopLatency");
    end

    for (genvar i = 0; i < 5; i++) begin : g_port
        if (Ports[i]) begin : g_on
            logic [Width-1:0] mem [Depth];
            logic [PW-1:0]    rd, wr;
            logic [CW-1:0]    cnt;
            logic             err, push, pop, push_ok;
            always_comb begin
                push    = !data_void_in[i];
                pop     = cnt != '0 && !stop_in[i];
                push_ok = push && (cnt != CW'(Depth) || pop);
            end
            // Pointers wrap explicitly so non-power-of-2 depths work; cnt alone tells full from empty.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                    rd  <= '0;
                    wr  <= '0;
                    err <= 1'b0;
                end else begin
                    cnt <= cnt + CW'(push_ok) - CW'(pop);
                    if (pop) rd <= rd == PW'(Depth - 1) ? '0 : rd + 1'b1;
                    if (push_ok) wr <= wr == PW'(Depth - 1) ? '0 : wr + 1'b1;
                    if (push && !push_ok) err <= 1'b1;
                end
            end
            always_ff @(posedge clk) begin
                if (push_ok) mem[wr] <= data_in[i*Width +: Width];
            end
            assign data_out[i*Width +: Width] = cnt == '0 ? '0 : mem[rd];
            assign data_void_out[i]           = cnt == '0;
            assign stop_out[i]                = cnt >= CW'(Depth - StopLatency);
            assign occupancy[i*CW +: CW]      = cnt;
            assign overflow_err[i]            = err;
        end else begin : g_off
            logic unused_in;
            assign unused_in                  = ^{data_in[i*Width +: Width], data_void_in[i], stop_in[i]};
            assign data_out[i*Width +: Width] = '0;
            assign data_void_out[i]           = 1'b1;
            assign stop_out[i]                = 1'b0;
            assign occupancy[i*CW +: CW]      = '0;
            assign overflow_err[i]            = 1'b0;
        end
    end
endmodule

// File: tb/tb_lookahead_port_buffer_array.sv
// tb_lookahead_port_buffer_array: directed checks of latency, threshold, overflow, wrap, disabled port, async reset.
// u0 uses default parameters; u1 uses Depth=3 with port P disabled.
module tb_lookahead_port_buffer_array;
    localparam int W = 66;

    logic           clk = 1'b0;
    logic           rst;
    logic [5*W-1:0] data_in;
    logic [4:0]     data_void_in;
    logic [4:0]     stop_in;

    logic [4:0]     stop0, void0, err0;
    logic [5*W-1:0] dout0;
    logic [14:0]    occ0;
    logic [4:0]     stop1, void1, err1;
    logic [5*W-1:0] dout1;
    logic [9:0]     occ1;

    int n_assert = 0;
    int n_fail   = 0;

    lookahead_port_buffer_array u0 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_void_in(data_void_in),
        .stop_out(stop0), .data_out(dout0), .data_void_out(void0),
        .stop_in(stop_in), .occupancy(occ0), .overflow_err(err0)
    );

    lookahead_port_buffer_array #(.Width(66), .Ports(5'b01111), .Depth(3), .StopLatency(1)) u1 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_void_in(data_void_in),
        .stop_out(stop1), .data_out(dout1), .data_void_out(void1),
        .stop_in(stop_in), .occupancy(occ1), .overflow_err(err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put(input int p, input logic [W-1:0] v);
        data_in[p*W +: W] = v;
        data_void_in[p]   = 1'b0;
    endtask

    task automatic idle();
        data_void_in = 5'b11111;
        data_in      = '0;
    endtask

    initial begin
        logic [W-1:0] q[$];
        int sent, rcvd, cyc;
        rst          = 1'b1;
        data_in      = '0;
        data_void_in = 5'b11111;
        stop_in      = 5'b00000;
        @(negedge clk);
        chk("rst_void", void0, 5'b11111);
        chk("rst_stop", stop0, 5'b00000);
        chk("rst_occ", occ0, 15'd0);
        chk("rst_dout", dout0, '0);
        chk("rst_err", err0, 5'b00000);
        rst = 1'b0;

        // Basic latency on N
        put(0, 66'h1A5);
        step();
        idle();
        chk("lat_void", void0[0], 1'b0);
        chk("lat_data", dout0[0 +: W], 66'h1A5);
        chk("lat_occ", occ0[2:0], 3'd1);
        step();
        chk("lat_void_back", void0[0], 1'b1);
        chk("lat_occ_back", occ0[2:0], 3'd0);

        // Threshold and absorption with downstream stalled
        stop_in[0] = 1'b1;
        put(0, 66'hA1); step();
        chk("thr_occ1", occ0[2:0], 3'd1);
        chk("thr_stop1", stop0[0], 1'b0);
        put(0, 66'hA2); step();
        chk("thr_stop2", stop0[0], 1'b0);
        put(0, 66'hA3); step();
        chk("thr_occ3", occ0[2:0], 3'd3);
        chk("thr_stop3", stop0[0], 1'b1);
        put(0, 66'hA4); step();
        chk("abs_occ4", occ0[2:0], 3'd4);
        chk("abs_err", err0[0], 1'b0);
        chk("abs_head", dout0[0 +: W], 66'hA1);
        put(0, 66'hA5); step();
        chk("ovf_occ", occ0[2:0], 3'd4);
        chk("ovf_err", err0[0], 1'b1);
        chk("ovf_head", dout0[0 +: W], 66'hA1);

        // Full queue with simultaneous push and pop
        stop_in[0] = 1'b0;
        put(0, 66'h3C); step();
        idle();
        chk("fpp_occ", occ0[2:0], 3'd4);
        chk("fpp_head", dout0[0 +: W], 66'hA2);
        step();
        chk("drain_a3", dout0[0 +: W], 66'hA3);
        chk("drain_occ3", occ0[2:0], 3'd3);
        step();
        chk("drain_a4", dout0[0 +: W], 66'hA4);
        chk("drain_stop_fall", stop0[0], 1'b0);
        step();
        chk("drain_3c", dout0[0 +: W], 66'h3C);
        step();
        chk("drain_empty", void0[0], 1'b1);
        chk("err_sticky", err0[0], 1'b1);

        // Async reset with two flits queued on W
        stop_in[2] = 1'b1;
        put(2, 66'hB1); step();
        put(2, 66'hB2); step();
        idle();
        chk("ar_occ_pre", occ0[8:6], 3'd2);
        #2 rst = 1'b1;
        #1;
        chk("ar_void", void0[2], 1'b1);
        chk("ar_occ", occ0[8:6], 3'd0);
        chk("ar_dout", dout0[2*W +: W], '0);
        chk("ar_err", err0, 5'b00000);
        #1 rst = 1'b0;
        @(negedge clk);
        stop_in = 5'b00000;
        put(2, 66'hC7); step();
        idle();
        chk("ar_post_void", void1[2], 1'b0);
        chk("ar_post_data", dout0[2*W +: W], 66'hC7);
        step();

        // Wrap-around on E of the Depth=3 instance with random backpressure
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 20 && cyc < 400) begin
            stop_in[3] = 1'($urandom_range(0, 2) == 0);
            if (!void1[3] && !stop_in[3]) begin
                chk("wrap_data", dout1[3*W +: W], q.size() != 0 ? q[0] : 66'h0);
                if (q.size() != 0) void'(q.pop_front());
                rcvd++;
            end
            if (sent < 20 && occ1[7:6] < 2'd3) begin
                put(3, 66'h2_0000_0000_0000_0100 + 66'(sent));
                q.push_back(66'h2_0000_0000_0000_0100 + 66'(sent));
                sent++;
            end
            step();
            idle();
            n_assert++;
            assert (occ1[7:6] <= 2'd3) else begin
                n_fail++;
                $error("FAIL wrap_occ observed=%0d expected<=3", occ1[7:6]);
            end
            cyc++;
        end
        chk("wrap_count", 32'(rcvd), 32'd20);
        chk("wrap_err", err1[3], 1'b0);
        stop_in = 5'b00000;

        // Disabled port P on u1
        stop_in[4] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            put(4, 66'h500 + 66'(k));
            step();
            chk("dis_void", void1[4], 1'b1);
            chk("dis_stop", stop1[4], 1'b0);
            chk("dis_err", err1[4], 1'b0);
            chk("dis_occ", occ1[9:8], 2'd0);
        end
        chk("en_p_u0_err", err0[4], 1'b1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
